// File: rtl/int_div.sv
// rtl/int_div.sv - iterative radix-2^B RV32M divider (DIV/DIVU/REM/REMU), optional INT_DIV_EARLY_EXIT_EN
package int_div_pkg;
    typedef logic [2:0] alu_t;
    localparam alu_t ALU_DIV  = 3'd4;
    localparam alu_t ALU_DIVU = 3'd5;
    localparam alu_t ALU_REM  = 3'd6;
    localparam alu_t ALU_REMU = 3'd7;
endpackage

module int_div
    import int_div_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  alu_t        alu_op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);
    localparam int         N    = 32 / BITS_PER_CYCLE;
    localparam logic [4:0] LAST = 5'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t      state_q;
    logic        in_ready_q, out_valid_q;
    logic [31:0] result_q;
    logic [31:0] quo_q, quo_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] dvs_q;
    logic [4:0]  cnt_q;
    logic        sel_rem_q, neg_quo_q, neg_rem_q;

    logic        op_legal, op_signed, op_rem, a_neg, b_neg, ovf, early;
    logic [31:0] a_mag, b_mag, fix_quo, fix_rem;

    assign op_legal  = (alu_op == ALU_DIV) || (alu_op == ALU_DIVU) ||
                       (alu_op == ALU_REM) || (alu_op == ALU_REMU);
    assign op_signed = (alu_op == ALU_DIV) || (alu_op == ALU_REM);
    assign op_rem    = (alu_op == ALU_REM) || (alu_op == ALU_REMU);
    assign a_neg     = op_signed & rs1[31];
    assign b_neg     = op_signed & rs2[31];
    assign a_mag     = a_neg ? (32'd0 - rs1) : rs1;
    assign b_mag     = b_neg ? (32'd0 - rs2) : rs2;
    assign ovf       = op_signed && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);

    // Divisor is known nonzero wherever early is consulted.
`ifdef INT_DIV_EARLY_EXIT_EN
    assign early = (a_mag < b_mag);
`else
    assign early = 1'b0;
`endif

    // Restoring shift-subtract: the dividend shifts out of quo while quotient bits shift in.
    always_comb begin
        quo_d = quo_q;
        rem_d = rem_q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            rem_d = {rem_d[31:0], quo_d[31]};
            quo_d = {quo_d[30:0], 1'b0};
            if (rem_d >= {1'b0, dvs_q}) begin
                rem_d    = rem_d - {1'b0, dvs_q};
                quo_d[0] = 1'b1;
            end
        end
    end

    assign fix_quo = neg_quo_q ? (32'd0 - quo_q) : quo_q;
    assign fix_rem = neg_rem_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            sel_rem_q   <= 1'b0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    in_ready_q <= 1'b0;
                    cnt_q      <= '0;
                    sel_rem_q  <= op_rem;
                    neg_quo_q  <= 1'b0;
                    neg_rem_q  <= 1'b0;
                    state_q    <= S_FIX;
                    // Special cases preload quo/rem with the final answer and bypass CALC.
                    if (!op_legal) begin
                        quo_q <= 32'hDEAD_BEEF;
                        rem_q <= {1'b0, 32'hDEAD_BEEF};
                    end else if (rs2 == 32'd0) begin
                        quo_q <= 32'hFFFF_FFFF;
                        rem_q <= {1'b0, rs1};
                    end else if (ovf) begin
                        quo_q <= 32'h8000_0000;
                        rem_q <= '0;
                    end else begin
                        neg_quo_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        dvs_q     <= b_mag;
                        if (early) begin
                            quo_q <= '0;
                            rem_q <= {1'b0, a_mag};
                        end else begin
                            quo_q   <= a_mag;
                            rem_q   <= '0;
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    quo_q <= quo_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == LAST) state_q <= S_FIX;
                end
                S_FIX: begin
                    result_q    <= sel_rem_q ? fix_rem : fix_quo;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
endmodule

// File: tb/tb_int_div.sv
// tb/tb_int_div.sv - self-checking bench for int_div (vector table, corner sequences, random vs reference model)
module tb_int_div;
    import int_div_pkg::*;

    parameter int BITS_PER_CYCLE = 1;
    localparam int N = 32 / BITS_PER_CYCLE;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] rs1, rs2, result;
    alu_t        alu_op;

    int checks = 0;
    int errors = 0;

    int_div #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .alu_op(alu_op), .out_valid(out_valid),
        .out_ready(out_ready), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        alu_t        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          spec;
        bit          early;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic longint magn(input logic [31:0] v, input bit sgn);
        longint x;
        x = sgn ? longint'($signed(v)) : longint'({32'd0, v});
        return (x < 0) ? -x : x;
    endfunction

    function automatic logic [31:0] ref_result(input alu_t op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        bit sgn;
        if (!(op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU})) return 32'hDEAD_BEEF;
        if (b == 32'd0) return (op == ALU_DIV || op == ALU_DIVU) ? 32'hFFFF_FFFF : a;
        sgn = (op == ALU_DIV || op == ALU_REM);
        sa  = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        sb  = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        q   = sa / sb;
        r   = sa % sb;
        return (op == ALU_DIV || op == ALU_DIVU) ? q[31:0] : r[31:0];
    endfunction

    function automatic int ref_latency(input alu_t op, input logic [31:0] a, input logic [31:0] b);
        bit sgn;
        sgn = (op == ALU_DIV || op == ALU_REM);
        if (!(op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU}) || b == 32'd0) return 1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef INT_DIV_EARLY_EXIT_EN
        if (magn(a, sgn) < magn(b, sgn)) return 1;
`endif
        return N + 1;
    endfunction

    task automatic start_op(input alu_t op, input logic [31:0] a, input logic [31:0] b);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        alu_op   = op;
        rs1      = a;
        rs2      = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_result(output logic [31:0] res, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!out_valid && lat < 200);
        res = result;
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("consume_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    vec_t vecs[12];

    initial begin
        logic [31:0] res, first;
        int          lat, hits, fl_at;
        alu_t        op;
        logic [31:0] a, b;

        vecs[0]  = '{ALU_DIVU, 32'd100,        32'd7,          32'd14,         1'b0, 1'b0};
        vecs[1]  = '{ALU_REMU, 32'd100,        32'd7,          32'd2,          1'b0, 1'b0};
        vecs[2]  = '{ALU_DIV,  32'hFFFF_FFEC,  32'd3,          32'hFFFF_FFFA,  1'b0, 1'b0};
        vecs[3]  = '{ALU_REM,  32'hFFFF_FFEC,  32'd3,          32'hFFFF_FFFE,  1'b0, 1'b0};
        vecs[4]  = '{ALU_REM,  32'd20,         32'hFFFF_FFFD,  32'd2,          1'b0, 1'b0};
        vecs[5]  = '{ALU_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, 1'b0};
        vecs[6]  = '{ALU_REMU, 32'd5,          32'd0,          32'd5,          1'b1, 1'b0};
        vecs[7]  = '{ALU_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1, 1'b0};
        vecs[8]  = '{ALU_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0};
        vecs[9]  = '{alu_t'(3'd1), 32'd1,      32'd1,          32'hDEAD_BEEF,  1'b1, 1'b0};
        vecs[10] = '{ALU_DIVU, 32'd3,          32'd10,         32'd0,          1'b0, 1'b1};
        vecs[11] = '{ALU_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0, 1'b0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        rs1 = '0; rs2 = '0; alu_op = ALU_DIVU;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_result", result, 32'd0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            int exp_lat;
            exp_lat = vecs[i].spec ? 1 : N + 1;
`ifdef INT_DIV_EARLY_EXIT_EN
            if (vecs[i].early) exp_lat = 1;
`endif
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_result(res, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_lat));
            consume();
        end

        // Result must hold while the consumer stalls.
        start_op(ALU_DIV, 32'hFFFF_FFEC, 32'd3);
        wait_result(first, lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold_result", result, 32'hFFFF_FFFA);
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        consume();

        // A second request during CALC must be ignored.
        start_op(ALU_DIVU, 32'd1000, 32'd10);
        repeat (2) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b1; rs1 = 32'd77; rs2 = 32'd0; alu_op = ALU_REMU;
        repeat (3) @(posedge clk);
        #1;
        check("busy_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        wait_result(res, lat);
        check("busy_ignore_result", res, 32'd100);
        consume();
        repeat (N + 4) @(posedge clk);
        #1 check("busy_no_second_result", {31'd0, out_valid}, 32'd0);

        // Flush part-way through CALC.
        fl_at = (N > 12) ? 10 : N - 2;
        start_op(ALU_DIVU, 32'hFFFF_FFF0, 32'd3);
        repeat (fl_at) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        hits = 0;
        for (int i = 0; i < N + 4; i++) begin
            @(posedge clk);
            #1 if (out_valid) hits++;
        end
        check("flush_no_out_valid", 32'(hits), 32'd0);
        check("flush_result_kept", result, 32'd100);
        start_op(ALU_DIVU, 32'd9, 32'd3);
        wait_result(res, lat);
        check("post_flush_result", res, 32'd3);
        check("post_flush_latency", 32'(lat), 32'(N + 1));
        consume();

        // Flush on the accept edge drops the operation.
        @(negedge clk);
        in_valid = 1'b1; rs1 = 32'd5; rs2 = 32'd0; alu_op = ALU_DIV; flush = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        flush = 1'b0;
        check("accept_flush_in_ready", {31'd0, in_ready}, 32'd1);
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 if (out_valid) hits++;
        end
        check("accept_flush_no_out", 32'(hits), 32'd0);

        // Reset mid-operation restores reset values.
        start_op(ALU_DIVU, 32'd1234, 32'd5);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_result", result, 32'd0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 150; i++) begin
            int r;
            r  = $urandom_range(0, 9);
            op = (r < 8) ? alu_t'(3'd4 + 3'(r % 4)) : alu_t'($urandom_range(0, 3));
            a  = rnd_operand();
            b  = rnd_operand();
            start_op(op, a, b);
            wait_result(res, lat);
            check($sformatf("rand%0d_result op=%0d a=%h b=%h", i, op, a, b), res, ref_result(op, a, b));
            check($sformatf("rand%0d_latency", i), 32'(lat), 32'(ref_latency(op, a, b)));
            consume();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/int_div.md
Name: int_div

Overview:
- Iterative radix-2^B integer divider for the RV32M M-extension: DIV, DIVU, REM, REMU.
- Sits beside the combinational integer multiplier in the execute stage; together they complete the M extension.
- Multi-cycle, so it has a valid/ready handshake on both sides and a flush input.
- Issue logic stalls the pipeline while in_ready is low or until out_valid is consumed.

Parameters:
- BITS_PER_CYCLE, 1, quotient bits resolved per CALC cycle. Legal values 1, 2, 4. Iterations N = 32/BITS_PER_CYCLE.

Ports:
- clk  input  1  core clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  abort any operation in flight; takes priority over everything except rst
- in_valid  input  1  operands and op present
- in_ready  output  1  high only in IDLE
- rs1  input  32  dividend
- rs2  input  32  divisor
- alu_op  input  alu_t  one of DIV, DIVU, REM, REMU
- out_valid  output  1  result valid, held until accepted
- out_ready  input  1  consumer accepts result
- result  output  32  quotient (DIV/DIVU) or remainder (REM/REMU)

Behaviour:
- One clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, all internal registers 0.
- States:
  - IDLE: in_ready=1. On in_valid, capture op, signs and operand magnitudes; go to CALC, or to FIX on a special case.
  - CALC: restoring shift-subtract, BITS_PER_CYCLE bits per cycle, iteration counter counting 0..N-1. Go to FIX after the N-th iteration.
  - FIX: apply sign correction, register result, set out_valid=1; go to DONE.
  - DONE: hold result and out_valid. When out_ready=1, clear out_valid and go to IDLE; in_ready rises the following cycle (no same-cycle reissue).
- Latency, measured from the accept edge:
  - Normal path: out_valid rises after edge N+1 (33 for B=1, 17 for B=2, 9 for B=4).
  - Special-case path: out_valid rises after edge 1.
- Signed ops (DIV/REM):
  - Divide the magnitudes.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- Unsigned ops (DIVU/REMU): operands are used raw.
- Special cases, resolved at accept, skip CALC:
  - Divide by zero (rs2=0): DIV/DIVU result = 32'hFFFFFFFF; REM/REMU result = rs1.
  - Signed overflow (DIV/REM with rs1=32'h80000000, rs2=32'hFFFFFFFF): DIV result = 32'h80000000; REM result = 0.
  - Any other alu_op value: result = 32'hDEADBEEF.
- Arithmetic width: partial remainder is 33 bits, so no overflow of intermediate values.
- Input handshake: in_valid is ignored while in_ready=0. The unit never accepts a second operation before the first is consumed.
- flush: next edge forces IDLE and out_valid=0; result keeps its last value. Applies to an accept edge too (the captured op is dropped).
- rst mid-operation: identical to reset values; no residual output.
- out_ready while out_valid=0: ignored.

Optional Feature:
- INT_DIV_EARLY_EXIT_EN
  - Defined: at accept, if |dividend| < |divisor| as unsigned magnitudes and the divisor is nonzero, skip CALC and go straight to FIX. Quotient = 0, remainder = dividend (sign-corrected as usual). Latency is 1 cycle.
  - Undefined: every non-special operation takes the full N+1 cycles.
  - Results are bit-identical either way; only latency differs.

Test Plan:
- DIVU rs1=100, rs2=7 (B=1) -> out_valid after 33 cycles, result=14. Repeat with REMU -> result=2.
- DIV rs1=-20 (32'hFFFFFFEC), rs2=3 -> result=32'hFFFFFFFA (-6). REM same operands -> result=32'hFFFFFFFE (-2). REM rs1=20, rs2=-3 -> result=2.
- Divide by zero: DIV rs1=5, rs2=0 -> 32'hFFFFFFFF after 1 cycle. REMU rs1=5, rs2=0 -> 5 after 1 cycle.
- Overflow: DIV 32'h80000000 / 32'hFFFFFFFF -> result=32'h80000000. REM same operands -> result=0. Both after 1 cycle.
- Handshake:
  - Hold out_ready=0 for 10 cycles after out_valid -> result stable and in_ready=0 throughout.
  - Assert in_valid with different operands during CALC -> ignored, first result unaffected.
- flush at iteration 10 -> out_valid never rises, IDLE and in_ready=1 on the next cycle; a new DIVU 9/3 then returns 3.
- With INT_DIV_EARLY_EXIT_EN: DIVU 3/10 -> result=0, latency 1 cycle.
- Repeat all scenarios for BITS_PER_CYCLE=2 and 4 -> same results, latency 17 and 9 cycles respectively.
